// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: arms on start, waits a pseudo-random delay, lights
// the stimulus LED, then captures the external ms counter on stop (or flags foul/timeout).
module reaction_timer_ctrl #(
  parameter int CLKS_PER_MS  = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 1999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] ms_count,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic        stim_led,
  output logic [10:0] result_ms,
  output logic        result_valid,
  output logic        foul,
  output logic        timeout
);

  localparam int TICK_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  // Wide enough for MIN_DELAY_MS + 1020 with headroom, so the target never wraps.
  localparam int DELAY_W = $clog2(MIN_DELAY_MS + 1021) + 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLKS_PER_MS - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
  localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] DELAY_BASE = DELAY_W'(MIN_DELAY_MS);
  localparam logic [10:0]        MAX_MS_V   = 11'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TIMING,
    S_DONE,
    S_FOUL
  } state_t;

  state_t             state;
  state_t             state_next;

  logic               start_q;
  logic               stop_q;
  logic               start_rise;
  logic               stop_rise;

  logic [7:0]         lfsr;
  logic               lfsr_fb;

  logic [TICK_W-1:0]  tick;
  logic [DELAY_W-1:0] delay_ms;
  logic [DELAY_W-1:0] delay_target;
  logic               tick_wrap;
  logic               delay_done;

  logic               arm;
  logic               take_stop;
  logic               take_timeout;
  logic               take_foul;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; the all-zero state is unreachable from 8'h01.
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign tick_wrap  = (tick == TICK_LAST);
  assign delay_done = (delay_ms == delay_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    arm          = 1'b0;
    take_stop    = 1'b0;
    take_timeout = 1'b0;
    take_foul    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FOUL: begin
        if (start_rise) begin
          arm        = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // An early press outranks the delay expiring on the same edge.
        if (stop_rise) begin
          take_foul  = 1'b1;
          state_next = S_FOUL;
        end else if (delay_done) begin
          state_next = S_TIMING;
        end
      end
      S_TIMING: begin
        if (stop_rise) begin
          take_stop  = 1'b1;
          state_next = S_DONE;
        end else if (ms_count >= MAX_MS_V) begin
          take_timeout = 1'b1;
          state_next   = S_DONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore decode: the counter is held cleared everywhere except TIMING and DONE.
  always_comb begin
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    stim_led = 1'b0;
    case (state)
      S_TIMING: begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b1;
        stim_led = 1'b1;
      end
      S_DONE: begin
        cnt_clr  = 1'b0;
      end
      default: begin
        cnt_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      lfsr         <= 8'h01;
      tick         <= '0;
      delay_ms     <= '0;
      delay_target <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      lfsr    <= {lfsr[6:0], lfsr_fb};

      if (arm) begin
        delay_target <= DELAY_BASE + DELAY_W'({lfsr, 2'b00});
        tick         <= '0;
        delay_ms     <= '0;
        result_valid <= 1'b0;
        foul         <= 1'b0;
        timeout      <= 1'b0;
      end else if (state == S_WAIT) begin
        if (tick_wrap) begin
          tick     <= '0;
          delay_ms <= delay_ms + DELAY_ONE;
        end else begin
          tick <= tick + TICK_ONE;
        end
      end

      if (take_foul) begin
        foul <= 1'b1;
      end
      if (take_stop) begin
        result_ms    <= ms_count;
        result_valid <= 1'b1;
      end
      if (take_timeout) begin
        result_ms <= MAX_MS_V;
        timeout   <= 1'b1;
      end
    end
  end

endmodule
